// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - BTB/BHT branch predictor with EX-side resolution; optional RAS via BPU_RAS_EN
module branch_predict_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int BTB_ENTRIES = 16,
    parameter int CNT_W       = 2,
    parameter int RAS_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc_i,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    input  logic            ex_valid_i,
    input  logic            ex_stall_i,
    input  logic [6:0]      ex_opcode_i,
    input  logic [2:0]      ex_func3_i,
    input  logic [4:0]      ex_rd_i,
    input  logic [4:0]      ex_rs1_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic [XLEN-1:0] ex_ra_i,
    input  logic [XLEN-1:0] ex_rb_i,
    input  logic [XLEN-1:0] ex_imm_i,
    input  logic            ex_pred_taken_i,
    input  logic [XLEN-1:0] ex_pred_target_i,
    output logic            jump_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            flush_o
);
    localparam int BHT_IW = $clog2(BHT_ENTRIES);
    localparam int BTB_IW = $clog2(BTB_ENTRIES);
    localparam int TAG_W  = XLEN - BTB_IW - 2;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [XLEN-1:0] PC_INC = XLEN'(4);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        T_BRANCH = 2'b00,
        T_JUMP   = 2'b01,
        T_RET    = 2'b10
    } btb_type_e;

    logic             btb_valid_q  [BTB_ENTRIES];
    logic [TAG_W-1:0] btb_tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0]  btb_target_q [BTB_ENTRIES];
    btb_type_e        btb_type_q   [BTB_ENTRIES];
    logic [CNT_W-1:0] bht_q        [BHT_ENTRIES];
    logic             flush_q, flush_d;

    logic [BTB_IW-1:0] if_btb_idx, ex_btb_idx;
    logic [BHT_IW-1:0] if_bht_idx, ex_bht_idx;
    logic [TAG_W-1:0]  if_tag, ex_tag;
    logic              if_hit, if_taken;
    logic [XLEN-1:0]   if_target;

    logic              is_jal, is_jalr, is_br, br_ok, br_taken;
    logic              ex_ctrl, actual_taken, mispredict, train;
    logic              link_rd, link_rs1;
    logic [XLEN-1:0]   ex_target;
    btb_type_e         ex_type;
    logic [CNT_W-1:0]  bht_cnt_d;

`ifdef BPU_RAS_EN
    localparam int RAS_PW = $clog2(RAS_DEPTH);
    localparam logic [RAS_PW:0] RAS_FULL = (RAS_PW + 1)'(RAS_DEPTH);

    // ras_ptr_q is the next free slot; the top of stack sits just below it
    logic [XLEN-1:0]   ras_q [RAS_DEPTH];
    logic [RAS_PW-1:0] ras_ptr_q, ras_ptr_d, ras_wr_idx, ras_top_idx;
    logic [RAS_PW:0]   ras_cnt_q, ras_cnt_d;
    logic              ras_push, ras_pop, ras_we;
`endif

    assign if_btb_idx = if_pc_i[BTB_IW+1:2];
    assign if_bht_idx = if_pc_i[BHT_IW+1:2];
    assign if_tag     = if_pc_i[XLEN-1:BTB_IW+2];
    assign ex_btb_idx = ex_pc_i[BTB_IW+1:2];
    assign ex_bht_idx = ex_pc_i[BHT_IW+1:2];
    assign ex_tag     = ex_pc_i[XLEN-1:BTB_IW+2];

    // IF lookup reads only the registered tables, so a same-cycle update is not visible here
    always_comb begin
        if_hit    = btb_valid_q[if_btb_idx] && (btb_tag_q[if_btb_idx] == if_tag);
        if_taken  = if_hit && ((btb_type_q[if_btb_idx] != T_BRANCH) || bht_q[if_bht_idx][CNT_W-1]);
        if_target = btb_target_q[if_btb_idx];
`ifdef BPU_RAS_EN
        ras_top_idx = ras_ptr_q - 1'b1;
        if ((btb_type_q[if_btb_idx] == T_RET) && (ras_cnt_q != '0)) begin
            if_target = ras_q[ras_top_idx];
        end
`endif
        pred_taken_o  = if_taken;
        pred_target_o = if_taken ? if_target : if_pc_i + PC_INC;
    end

    always_comb begin
        is_jal   = (ex_opcode_i == OP_JAL);
        is_jalr  = (ex_opcode_i == OP_JALR);
        is_br    = (ex_opcode_i == OP_BRANCH);
        br_ok    = 1'b1;
        br_taken = 1'b0;
        case (ex_func3_i)
            3'b000:  br_taken = (ex_ra_i == ex_rb_i);
            3'b001:  br_taken = (ex_ra_i != ex_rb_i);
            3'b100:  br_taken = ($signed(ex_ra_i) <  $signed(ex_rb_i));
            3'b101:  br_taken = ($signed(ex_ra_i) >= $signed(ex_rb_i));
            3'b110:  br_taken = (ex_ra_i <  ex_rb_i);
            3'b111:  br_taken = (ex_ra_i >= ex_rb_i);
            default: br_ok    = 1'b0;
        endcase

        ex_ctrl      = ex_valid_i && (is_jal || is_jalr || (is_br && br_ok));
        actual_taken = ex_valid_i && (is_jal || is_jalr || (is_br && br_ok && br_taken));
        if (is_jalr) begin
            ex_target = (ex_ra_i + ex_imm_i) & ~XLEN'(1);
        end else begin
            ex_target = ex_pc_i + ex_imm_i;
        end

        mispredict = (actual_taken != ex_pred_taken_i) ||
                     (actual_taken && (ex_target != ex_pred_target_i));
        redirect_o = ex_valid_i && !ex_stall_i && mispredict;
        if (redirect_o) begin
            redirect_pc_o = actual_taken ? ex_target : ex_pc_i + PC_INC;
        end else begin
            redirect_pc_o = '0;
        end
        jump_o  = ex_valid_i && (is_jal || is_jalr);
        flush_d = redirect_o;
        train   = ex_ctrl && !ex_stall_i;

        link_rd  = (ex_rd_i == 5'd1) || (ex_rd_i == 5'd5);
        link_rs1 = (ex_rs1_i == 5'd1) || (ex_rs1_i == 5'd5);
        if (is_jalr && link_rs1 && !link_rd) begin
            ex_type = T_RET;
        end else if (is_jal || is_jalr) begin
            ex_type = T_JUMP;
        end else begin
            ex_type = T_BRANCH;
        end

        bht_cnt_d = bht_q[ex_bht_idx];
        if (actual_taken) begin
            if (bht_cnt_d != CNT_MAX) bht_cnt_d = bht_cnt_d + 1'b1;
        end else begin
            if (bht_cnt_d != '0) bht_cnt_d = bht_cnt_d - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_q <= 1'b0;
            for (int i = 0; i < BTB_ENTRIES; i++) btb_valid_q[i] <= 1'b0;
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CNT_INIT;
        end else begin
            flush_q <= flush_d;
            if (train) begin
                bht_q[ex_bht_idx] <= bht_cnt_d;
                if (actual_taken) btb_valid_q[ex_btb_idx] <= 1'b1;
            end
        end
    end

    // Entry payload needs no reset: it is qualified by btb_valid_q
    always_ff @(posedge clk) begin
        if (train && actual_taken) begin
            btb_tag_q[ex_btb_idx]    <= ex_tag;
            btb_target_q[ex_btb_idx] <= ex_target;
            btb_type_q[ex_btb_idx]   <= ex_type;
        end
    end

    assign flush_o = flush_q;

`ifdef BPU_RAS_EN
    // A call whose rs1 is the other link register is a coroutine swap: pop, then push
    always_comb begin
        ras_push   = (is_jal || is_jalr) && link_rd;
        ras_pop    = is_jalr && link_rs1 && (!link_rd || (ex_rd_i != ex_rs1_i));
        ras_ptr_d  = ras_ptr_q;
        ras_cnt_d  = ras_cnt_q;
        ras_we     = 1'b0;
        ras_wr_idx = ras_ptr_q;
        if (train) begin
            if (ras_pop && (ras_cnt_q != '0)) begin
                ras_ptr_d = ras_ptr_q - 1'b1;
                ras_cnt_d = ras_cnt_q - 1'b1;
            end
            if (ras_push) begin
                ras_we     = 1'b1;
                ras_wr_idx = ras_ptr_d;
                ras_ptr_d  = ras_ptr_d + 1'b1;
                if (ras_cnt_d != RAS_FULL) ras_cnt_d = ras_cnt_d + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else begin
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ras_we) ras_q[ras_wr_idx] <= ex_pc_i + PC_INC;
    end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - scoreboard bench for branch_predict_unit (RAS cases with BPU_RAS_EN)
module tb_branch_predict_unit;
    localparam logic [6:0] JAL  = 7'h6F;
    localparam logic [6:0] JALR = 7'h67;
    localparam logic [6:0] BR   = 7'h63;
    localparam logic [6:0] ALU  = 7'h33;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] if_pc = 32'h100;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid = 1'b0, ex_stall = 1'b0;
    logic [6:0]  ex_opcode = '0;
    logic [2:0]  ex_func3 = '0;
    logic [4:0]  ex_rd = '0, ex_rs1 = '0;
    logic [31:0] ex_pc = '0, ex_ra = '0, ex_rb = '0, ex_imm = '0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_pred_target = '0;
    logic        jump, redirect, flush;
    logic [31:0] redirect_pc;

    branch_predict_unit dut (
        .clk(clk), .rst(rst), .if_pc_i(if_pc),
        .pred_taken_o(pred_taken), .pred_target_o(pred_target),
        .ex_valid_i(ex_valid), .ex_stall_i(ex_stall), .ex_opcode_i(ex_opcode),
        .ex_func3_i(ex_func3), .ex_rd_i(ex_rd), .ex_rs1_i(ex_rs1), .ex_pc_i(ex_pc),
        .ex_ra_i(ex_ra), .ex_rb_i(ex_rb), .ex_imm_i(ex_imm),
        .ex_pred_taken_i(ex_pred_taken), .ex_pred_target_i(ex_pred_target),
        .jump_o(jump), .redirect_o(redirect), .redirect_pc_o(redirect_pc), .flush_o(flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          kind;   // 0 prediction, 1 resolution, 2 flush
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic exp_flush_next = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int k, input string n, input logic [31:0] a,
                        input logic [31:0] b, input logic c);
        exp_t e;
        e.cyc = cyc; e.kind = k; e.name = n; e.a = a; e.b = b; e.c = c;
        sb.push_back(e);
    endtask

    task automatic lookup(input string n, input logic r, input logic [31:0] pc,
                          input logic ept, input logic [31:0] eptg);
        @(posedge clk); #1;
        rst = r; ex_valid = 1'b0; ex_stall = 1'b0; if_pc = pc;
        push(2, {n, "_flush"}, {31'b0, exp_flush_next}, 32'h0, 1'b0);
        push(0, {n, "_pred"}, {31'b0, ept}, eptg, 1'b0);
        exp_flush_next = 1'b0;
    endtask

    task automatic ex_op(input string n, input logic [6:0] op, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] pc,
                         input logic [31:0] ra, input logic [31:0] rb, input logic [31:0] imm,
                         input logic pt, input logic [31:0] ptg, input logic stall,
                         input logic er, input logic [31:0] erpc, input logic ej,
                         input logic [31:0] ipc = 32'hF000_0000, input logic ept = 1'b0,
                         input logic [31:0] eptg = 32'hF000_0004);
        @(posedge clk); #1;
        rst = 1'b0; ex_valid = 1'b1; ex_stall = stall; ex_opcode = op; ex_func3 = f3;
        ex_rd = rd; ex_rs1 = rs1; ex_pc = pc; ex_ra = ra; ex_rb = rb; ex_imm = imm;
        ex_pred_taken = pt; ex_pred_target = ptg; if_pc = ipc;
        push(2, {n, "_flush"}, {31'b0, exp_flush_next}, 32'h0, 1'b0);
        push(1, {n, "_res"}, {31'b0, er}, erpc, ej);
        push(0, {n, "_pred"}, {31'b0, ept}, eptg, 1'b0);
        exp_flush_next = er;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] aa, bb;
            logic cc;
            e = sb.pop_front();
            checks++;
            case (e.kind)
                0:       begin aa = {31'b0, pred_taken}; bb = pred_target; cc = 1'b0; end
                1:       begin aa = {31'b0, redirect}; bb = redirect_pc; cc = jump; end
                default: begin aa = {31'b0, flush}; bb = 32'h0; cc = 1'b0; end
            endcase
            if (e.cyc != cyc || aa !== e.a || bb !== e.b || cc !== e.c) begin
                errors++;
                $display("FAIL %s (cycle %0d/%0d): got %0h/%0h/%0b, expected %0h/%0h/%0b",
                         e.name, cyc, e.cyc, aa, bb, cc, e.a, e.b, e.c);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        lookup("reset", 1'b1, 32'h100, 1'b0, 32'h104);
        // BEQ taken, then counter saturation at max
        ex_op("beq", BR, 3'd0, 5'd0, 5'd0, 32'h200, 32'd5, 32'd5, 32'h40, 1'b0, 32'h0, 1'b0, 1'b1, 32'h240, 1'b0);
        lookup("beq_l1", 1'b0, 32'h200, 1'b1, 32'h240);
        lookup("beq_l2", 1'b0, 32'h200, 1'b1, 32'h240);
        ex_op("beq_s1", BR, 3'd0, 5'd0, 5'd0, 32'h200, 32'd5, 32'd5, 32'h40, 1'b1, 32'h240, 1'b0, 1'b0, 32'h0, 1'b0);
        ex_op("beq_s2", BR, 3'd0, 5'd0, 5'd0, 32'h200, 32'd5, 32'd5, 32'h40, 1'b1, 32'h240, 1'b0, 1'b0, 32'h0, 1'b0);
        ex_op("beq_nt", BR, 3'd0, 5'd0, 5'd0, 32'h200, 32'd1, 32'd2, 32'h40, 1'b1, 32'h240, 1'b0, 1'b1, 32'h204, 1'b0);
        lookup("beq_l3", 1'b0, 32'h200, 1'b1, 32'h240);
        // signed vs unsigned compares
        ex_op("blt",  BR, 3'd4, 5'd0, 5'd0, 32'h208, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b1, 32'h218, 1'b0, 1'b0, 32'h0, 1'b0);
        ex_op("bltu", BR, 3'd6, 5'd0, 5'd0, 32'h20C, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b1, 32'h21C, 1'b0, 1'b1, 32'h210, 1'b0);
        ex_op("bge",  BR, 3'd5, 5'd0, 5'd0, 32'h220, 32'hFFFF_FFFF, 32'd1, 32'h8, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        ex_op("bgeu", BR, 3'd7, 5'd0, 5'd0, 32'h224, 32'hFFFF_FFFF, 32'd1, 32'h8, 1'b0, 32'h0, 1'b0, 1'b1, 32'h22C, 1'b0);
        // counter floor: three not-taken then one taken leaves it weakly not-taken
        for (int i = 0; i < 3; i++)
            ex_op("bne_nt", BR, 3'd1, 5'd0, 5'd0, 32'h210, 32'd7, 32'd7, 32'h20, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        ex_op("bne_t", BR, 3'd1, 5'd0, 5'd0, 32'h210, 32'd7, 32'd8, 32'h20, 1'b0, 32'h0, 1'b0, 1'b1, 32'h230, 1'b0);
        lookup("bne_l", 1'b0, 32'h210, 1'b0, 32'h214);
        // JALR target bit0 cleared; stalled mispredict has no effect
        ex_op("jalr", JALR, 3'd0, 5'd0, 5'd6, 32'h404, 32'h1001, 32'h0, 32'h4, 1'b1, 32'h1004, 1'b0, 1'b0, 32'h0, 1'b1);
        lookup("jalr_l", 1'b0, 32'h404, 1'b1, 32'h1004);
        ex_op("jalr_st", JALR, 3'd0, 5'd0, 5'd6, 32'h408, 32'h2000, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        lookup("stall_l", 1'b0, 32'h408, 1'b0, 32'h40C);
        // aliasing on the BTB index, back-to-back redirects
        ex_op("jal_a", JAL, 3'd0, 5'd0, 5'd0, 32'h40, 32'h0, 32'h0, 32'h100, 1'b0, 32'h0, 1'b0, 1'b1, 32'h140, 1'b1);
        ex_op("jal_b", JAL, 3'd0, 5'd0, 5'd0, 32'h80, 32'h0, 32'h0, 32'h80, 1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 1'b1);
        lookup("alias_a", 1'b0, 32'h40, 1'b0, 32'h44);
        lookup("alias_b", 1'b0, 32'h80, 1'b1, 32'h100);
        // non-control op predicted taken, reserved funct3
        ex_op("alu", ALU, 3'd0, 5'd0, 5'd0, 32'h500, 32'h0, 32'h0, 32'h0, 1'b1, 32'h600, 1'b0, 1'b1, 32'h504, 1'b0);
        ex_op("br010", BR, 3'd2, 5'd0, 5'd0, 32'h504, 32'd3, 32'd3, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        // same-cycle lookup of the index being trained sees the old entry
        ex_op("same", JAL, 3'd0, 5'd0, 5'd0, 32'h600, 32'h0, 32'h0, 32'h8, 1'b0, 32'h0, 1'b0, 1'b1, 32'h608, 1'b1,
              32'h600, 1'b0, 32'h604);
        lookup("same_l", 1'b0, 32'h600, 1'b1, 32'h608);
        lookup("mid_rst", 1'b1, 32'h600, 1'b0, 32'h604);
        lookup("post_rst", 1'b0, 32'h80, 1'b0, 32'h84);
`ifdef BPU_RAS_EN
        ex_op("call0", JAL, 3'd0, 5'd1, 5'd0, 32'h300, 32'h0, 32'h0, 32'h100, 1'b0, 32'h0, 1'b0, 1'b1, 32'h400, 1'b1);
        ex_op("ret0", JALR, 3'd0, 5'd0, 5'd1, 32'h408, 32'h304, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h304, 1'b1);
        ex_op("call1", JAL, 3'd0, 5'd1, 5'd0, 32'h500, 32'h0, 32'h0, 32'h10, 1'b0, 32'h0, 1'b0, 1'b1, 32'h510, 1'b1);
        lookup("ras_l", 1'b0, 32'h408, 1'b1, 32'h504);
        for (int k = 0; k < 5; k++)
            ex_op("call_k", JAL, 3'd0, 5'd1, 5'd0, 32'h700 + 32'(16 * k), 32'h0, 32'h0, 32'h10, 1'b1,
                  32'h710 + 32'(16 * k), 1'b0, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            logic [31:0] t;
            t = (k < 4) ? 32'h744 - 32'(16 * k) : 32'h714;
            ex_op("ret_k", JALR, 3'd0, 5'd0, 5'd1, 32'h408, t, 32'h0, 32'h0, 1'b1, t, 1'b0, 1'b0, 32'h0, 1'b1,
                  32'h408, 1'b1, t);
        end
        lookup("ras_empty", 1'b0, 32'h408, 1'b1, 32'h714);
        ex_op("call2", JAL, 3'd0, 5'd1, 5'd0, 32'h800, 32'h0, 32'h0, 32'h10, 1'b1, 32'h810, 1'b0, 1'b0, 32'h0, 1'b1);
        lookup("ras_after", 1'b0, 32'h408, 1'b1, 32'h804);
`endif
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised branch resolution and prediction unit.
- The IF-side lookup predicts taken/target from a tagged BTB plus a BHT of saturating counters.
- The EX-side resolution evaluates JAL/JALR/B-type outcomes, detects mispredicts, drives the PC redirect and a registered pipeline flush, and trains the tables.
- Sits between the IF PC mux and the EX stage of the pipeline.

Parameters:
- XLEN, 32, datapath/PC width.
- BHT_ENTRIES, 64, number of counters; power of 2, >=4.
- BTB_ENTRIES, 16, direct-mapped BTB entries; power of 2, >=2.
- CNT_W, 2, BHT counter width; >=1.
- RAS_DEPTH, 4, return-stack depth; power of 2; used only with BPU_RAS_EN.

Ports:
- clk in 1: clock.
- rst in 1: asynchronous, active-high reset.
- if_pc_i in XLEN: fetch PC.
- pred_taken_o out 1: IF prediction, taken.
- pred_target_o out XLEN: IF predicted next PC.
- ex_valid_i in 1: EX holds a valid instruction.
- ex_stall_i in 1: EX stalled (hazard); suppresses update, redirect and flush.
- ex_opcode_i in 7: EX opcode.
- ex_func3_i in 3: EX funct3.
- ex_rd_i in 5: EX rd index.
- ex_rs1_i in 5: EX rs1 index.
- ex_pc_i in XLEN: EX PC.
- ex_ra_i in XLEN: rs1 value.
- ex_rb_i in XLEN: rs2 value.
- ex_imm_i in XLEN: sign-extended B/J/I immediate, selected per opcode.
- ex_pred_taken_i in 1: prediction carried with the EX instruction.
- ex_pred_target_i in XLEN: predicted target carried with the EX instruction.
- jump_o out 1: EX instruction is JAL/JALR.
- redirect_o out 1: mispredict; IF must load redirect_pc_o.
- redirect_pc_o out XLEN: corrected next PC.
- flush_o out 1: registered flush of IF/ID, one cycle after redirect_o.

Behaviour:
- Indexing:
  - BHT idx = pc[log2(BHT_ENTRIES)+1:2].
  - BTB idx = pc[log2(BTB_ENTRIES)+1:2]; tag = remaining upper PC bits.
- BTB entry fields: valid, tag, target, type (00 branch, 01 jump, 10 return).
- IF lookup (combinational, reads table state only):
  - hit = valid && tag match.
  - pred_taken_o = hit && (type != branch || counter MSB == 1).
  - pred_target_o = taken ? entry target : if_pc_i + 4.
- EX resolve (combinational, gated by ex_valid_i):
  - JAL: taken; target = pc + imm.
  - JALR: taken; target = (ra + imm) with bit0 cleared.
  - B-type funct3: 000 EQ, 001 NE, 100 signed LT, 101 signed GE, 110 unsigned LT, 111 unsigned GE.
  - B-type funct3 010/011: resolved not-taken; no table update.
  - Any other opcode: not taken, jump_o = 0, no update.
- Mispredict = actual_taken != ex_pred_taken_i, OR (actual_taken && target != ex_pred_target_i), OR (!actual_taken && ex_pred_taken_i).
  - redirect_o = ex_valid_i && !ex_stall_i && mispredict.
  - redirect_pc_o = actual_taken ? target : ex_pc_i + 4.
  - redirect_pc_o = 0 when redirect_o is low.
- flush_o: registered copy of redirect_o. It is 1 for exactly one cycle per mispredict; a back-to-back redirect keeps it high.
- Training at posedge, only when ex_valid_i && !ex_stall_i and the instruction is a valid control transfer:
  - BHT counter saturating +1 if taken, -1 if not; no wrap at 0 or max.
  - BTB is written (valid, tag, target, type) on taken only; a not-taken branch leaves the BTB unchanged.
  - Type = return for JALR with rs1 in {x1, x5} and rd not in {x1, x5}; jump for other JAL/JALR; branch otherwise.
- Same-cycle IF lookup and EX update to the same index: IF sees the old value; there is no bypass.
- Reset (async):
  - All BTB valid bits cleared.
  - All BHT counters set to weakly-not-taken (MSB 0, rest 1; 2'b01 for CNT_W = 2).
  - flush_o = 0.
  - With no valid entries, pred_taken_o = 0 and pred_target_o = if_pc_i + 4.
  - Reset mid-operation discards all training.

Optional Feature:
- Macro BPU_RAS_EN, return-address stack of RAS_DEPTH entries, non-speculative.
- Updated at the EX training point:
  - Call (JAL/JALR, rd in {x1, x5}): push ex_pc_i + 4.
  - Return: pop.
  - Call that is also a return (rd and rs1 both link, rd != rs1): pop then push.
- Overflow: circular; overwrites the oldest entry, count saturates at RAS_DEPTH.
- Underflow: pop on empty is ignored.
- IF lookup: a return-type hit with non-empty RAS uses the RAS top as pred_target_o; otherwise the BTB target.
- Without the macro: no RAS storage; returns predict the BTB target only.
- Reset: RAS count = 0.

Test Plan:
- Reset, if_pc_i = 0x100 -> pred_taken_o = 0, pred_target_o = 0x104, flush_o = 0.
- BEQ at 0x200, ra = rb = 5, imm = 0x40, pred 0 -> redirect_o = 1, redirect_pc_o = 0x240, flush_o = 1 next cycle only. Then lookup at 0x200 -> counter 2'b10, pred_taken_o = 1, target 0x240.
- BLT with ra = 0xFFFFFFFF, rb = 1 -> taken; BLTU with the same operands -> not taken. Repeat BNE not-taken 3 times -> counter saturates at 0, no underflow.
- JALR ra = 0x1001, imm = 4, pred target 0x1004 -> actual target 0x1004 (bit0 cleared), no redirect. Same with ex_stall_i = 1 and a wrong prediction -> redirect_o = 0, no table write.
- Aliasing: JAL at 0x40 then JAL at 0x40 + 4*BTB_ENTRIES -> the second replaces the entry; lookup at 0x40 -> tag miss, pred_taken_o = 0.
- BPU_RAS_EN: JAL rd = x1 at 0x300 then JALR x0, 0(x1) (BTB return entry) -> IF predicts 0x304. RAS_DEPTH + 1 calls followed by RAS_DEPTH + 1 returns -> last pop ignored, no X values.
